// File: rtl/load_unit.sv
// load_unit: data-memory read path for LB/LH/LW/LBU/LHU.
// Accepts one load at a time, issues a word-aligned read, waits for the
// returned word (bounded by TIMEOUT_CYC), then extracts and extends the
// addressed byte/halfword for rd writeback.
//
// Optional feature macro: LOAD_MISALIGN_TRAP_EN
//   defined   : misaligned LH/LHU/LW skip the read and raise ld_err
//   undefined : misaligned loads use forced alignment, never error
//
// Ports
//   clk, reset (sync, active-low)
//   ld_req, funct3, daddr         load request (sampled in IDLE only)
//   ld_busy                       high whenever not IDLE
//   mem_re, mem_addr              memory read strobe / aligned word address
//   mem_rdata, mem_rvalid         memory read response
//   ld_valid, rd_data             result pulse / extended result (held)
//   ld_err                        illegal funct3, timeout or trapped misalign
module load_unit #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ld_req,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] daddr,
    output logic            ld_busy,
    output logic            mem_re,
    output logic [XLEN-1:0] mem_addr,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_rvalid,
    output logic            ld_valid,
    output logic [XLEN-1:0] rd_data,
    output logic            ld_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] cnt_inc;
    logic [2:0]       f3_q;
    logic [1:0]       lane_q;
    logic             bad_req_c;
    logic             bad_cur_c;
    logic             mis_req_c;
    logic             mis_cur_c;
    logic [7:0]       byte_c;
    logic [15:0]      half_c;
    logic [XLEN-1:0]  ext_c;

    // Only the five RV32 load encodings are legal.
    function automatic logic illegal_f3(input logic [2:0] f);
        case (f)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: illegal_f3 = 1'b0;
            default:                                illegal_f3 = 1'b1;
        endcase
    endfunction

`ifdef LOAD_MISALIGN_TRAP_EN
    // Size field funct3[1:0]: 01 half, 10 word.
    function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] l);
        case (sz)
            2'b01:   misaligned = l[0];
            2'b10:   misaligned = (l != 2'b00);
            default: misaligned = 1'b0;
        endcase
    endfunction

    assign mis_req_c = misaligned(funct3[1:0], daddr[1:0]);
    assign mis_cur_c = misaligned(f3_q[1:0], lane_q);
`else
    assign mis_req_c = 1'b0;
    assign mis_cur_c = 1'b0;
`endif

    // bad_req_c judges the incoming request; bad_cur_c the latched one.
    assign bad_req_c = illegal_f3(funct3) | mis_req_c;
    assign bad_cur_c = illegal_f3(f3_q) | mis_cur_c;
    assign cnt_inc   = cnt + CNT_W'(1);

    // Next-state and timeout counter.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            S_IDLE: if (ld_req) state_next = S_REQ;
            S_REQ:  state_next = bad_cur_c ? S_ERR : S_WAIT;
            S_WAIT: begin
                if (mem_rvalid) begin
                    state_next = S_DONE;
                    cnt_next   = '0;
                end else if (cnt_inc == CNT_W'(TIMEOUT_CYC)) begin
                    state_next = S_ERR;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            S_DONE:  state_next = S_IDLE;
            S_ERR:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Lane extraction; halfword uses lane[1] only, so misaligned halves
    // fall back to forced alignment when not trapping.
    always_comb begin
        byte_c = mem_rdata[7:0];
        case (lane_q)
            2'd0: byte_c = mem_rdata[7:0];
            2'd1: byte_c = mem_rdata[15:8];
            2'd2: byte_c = mem_rdata[23:16];
            2'd3: byte_c = mem_rdata[31:24];
            default: byte_c = mem_rdata[7:0];
        endcase
        half_c = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (f3_q)
            3'b000:  ext_c = {{(XLEN-8){byte_c[7]}}, byte_c};
            3'b100:  ext_c = {{(XLEN-8){1'b0}}, byte_c};
            3'b001:  ext_c = {{(XLEN-16){half_c[15]}}, half_c};
            3'b101:  ext_c = {{(XLEN-16){1'b0}}, half_c};
            default: ext_c = mem_rdata;
        endcase
    end

    // State register and registered state-decoded strobes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            ld_busy  <= 1'b0;
            mem_re   <= 1'b0;
            ld_valid <= 1'b0;
            ld_err   <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            ld_busy  <= (state_next != S_IDLE);
            // REQ is only entered from IDLE, so the incoming request decides.
            mem_re   <= (state_next == S_REQ) && !bad_req_c;
            ld_valid <= (state_next == S_DONE);
            ld_err   <= (state_next == S_ERR);
        end
    end

    // Request capture and result register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            f3_q     <= 3'b000;
            lane_q   <= 2'b00;
            mem_addr <= '0;
            rd_data  <= '0;
        end else begin
            if (state == S_IDLE && ld_req) begin
                f3_q     <= funct3;
                lane_q   <= daddr[1:0];
                mem_addr <= {daddr[XLEN-1:2], 2'b00};
            end
            if (state == S_WAIT && mem_rvalid) begin
                rd_data <= ext_c;
            end
        end
    end

endmodule
